// File: rtl/checksum_checker.sv
// Zero-latency AXI4-stream checker: forwards header and payload, strips the trailing
// XOR checksum byte, and reports per-packet checksum/length status plus saturating counters.
module checksum_checker (
    input  logic        aclk,
    input  logic        arst,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic [15:0] in_tdata,
    input  logic        in_tlast,
    output logic        out_tvalid,
    input  logic        out_tready,
    output logic [15:0] out_tdata,
    output logic [1:0]  out_tkeep,
    output logic        out_tlast,
    output logic        status_valid,
    output logic        status_ok,
    output logic        status_cks_err,
    output logic        status_len_err,
    output logic [3:0]  status_msg_type,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
);

    typedef enum logic [1:0] {S_HDR, S_DATA, S_CKS, S_DISCARD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_xor;
    logic [11:0] r_cnt;
    logic        r_len_odd;
    logic [3:0]  r_msg_type;

    logic        w_accept;
    logic        w_final;
    logic [7:0]  w_xor_beat;
    logic [11:0] w_hdr_len;
    logic [12:0] w_len_p1;
    logic        w_report;
    logic        w_cks_err;
    logic        w_len_err;
    logic [3:0]  w_msg_type;

    assign w_hdr_len  = in_tdata[11:0];
    assign w_len_p1   = {1'b0, w_hdr_len} + 13'd1;
    assign w_xor_beat = in_tdata[15:8] ^ in_tdata[7:0];
    assign w_final    = (r_cnt == 12'd1);
    assign w_accept   = in_tvalid && in_tready;
    // A len_err reported on the header beat itself has no latched type yet.
    assign w_msg_type = (r_state == S_HDR) ? in_tdata[15:12] : r_msg_type;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_HDR: begin
                    if (in_tlast)
                        w_state_nxt = S_HDR;
                    else if (w_hdr_len == 12'd0)
                        w_state_nxt = S_CKS;
                    else
                        w_state_nxt = S_DATA;
                end
                S_DATA: begin
                    if (in_tlast)
                        w_state_nxt = S_HDR;
                    else if (w_final)
                        w_state_nxt = r_len_odd ? S_DISCARD : S_CKS;
                    else
                        w_state_nxt = S_DATA;
                end
                S_CKS:     w_state_nxt = in_tlast ? S_HDR : S_DISCARD;
                S_DISCARD: w_state_nxt = in_tlast ? S_HDR : S_DISCARD;
                default:   w_state_nxt = S_HDR;
            endcase
        end
    end

    always_comb begin
        in_tready  = out_tready;
        out_tvalid = in_tvalid && !arst;
        out_tdata  = in_tdata;
        out_tkeep  = 2'b11;
        out_tlast  = 1'b0;
        w_report   = 1'b0;
        w_cks_err  = 1'b0;
        w_len_err  = 1'b0;
        case (r_state)
            S_HDR: begin
                out_tlast = (w_hdr_len == 12'd0) || in_tlast;
                w_report  = in_tlast;
                w_len_err = in_tlast;
            end
            S_DATA: begin
                if (w_final && r_len_odd) begin
                    out_tdata = {in_tdata[15:8], 8'h00};
                    out_tkeep = 2'b10;
                    out_tlast = 1'b1;
                    w_report  = 1'b1;
                    w_cks_err = ((r_xor ^ in_tdata[15:8]) != in_tdata[7:0]);
                    w_len_err = !in_tlast;
                end else begin
                    out_tlast = w_final || in_tlast;
                    w_report  = in_tlast;
                    w_len_err = in_tlast;
                end
            end
            S_CKS: begin
                in_tready  = 1'b1;
                out_tvalid = 1'b0;
                w_report   = 1'b1;
                w_cks_err  = (in_tdata[15:8] != r_xor);
                w_len_err  = !in_tlast;
            end
            S_DISCARD: begin
                in_tready  = 1'b1;
                out_tvalid = 1'b0;
            end
            default: begin
                in_tready  = out_tready;
            end
        endcase
    end

    // Running checksum and remaining payload-beat count advance only on accepted beats.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_xor      <= 8'h00;
            r_cnt      <= 12'd0;
            r_len_odd  <= 1'b0;
            r_msg_type <= 4'd0;
        end else if (w_accept) begin
            if (r_state == S_HDR) begin
                r_xor      <= w_xor_beat;
                r_cnt      <= w_len_p1[12:1];
                r_len_odd  <= w_hdr_len[0];
                r_msg_type <= in_tdata[15:12];
            end else if (r_state == S_DATA) begin
                r_xor <= r_xor ^ w_xor_beat;
                r_cnt <= r_cnt - 12'd1;
            end
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            status_valid    <= 1'b0;
            status_ok       <= 1'b0;
            status_cks_err  <= 1'b0;
            status_len_err  <= 1'b0;
            status_msg_type <= 4'd0;
            good_count      <= 16'd0;
            bad_count       <= 16'd0;
        end else begin
            status_valid <= w_accept && w_report;
            if (w_accept && w_report) begin
                status_ok       <= !w_cks_err && !w_len_err;
                status_cks_err  <= w_cks_err;
                status_len_err  <= w_len_err;
                status_msg_type <= w_msg_type;
                if (!w_cks_err && !w_len_err) begin
                    if (good_count != 16'hFFFF)
                        good_count <= good_count + 16'd1;
                end else begin
                    if (bad_count != 16'hFFFF)
                        bad_count <= bad_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_checksum_checker.sv
// Directed bench for checksum_checker: known packets with hand-computed outputs and status.
module tb_checksum_checker;

    logic        aclk = 1'b0;
    logic        arst = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [15:0] in_tdata = 16'h0000;
    logic        in_tlast = 1'b0;
    logic        out_tvalid;
    logic        out_tready = 1'b1;
    logic [15:0] out_tdata;
    logic [1:0]  out_tkeep;
    logic        out_tlast;
    logic        status_valid;
    logic        status_ok;
    logic        status_cks_err;
    logic        status_len_err;
    logic [3:0]  status_msg_type;
    logic [15:0] good_count;
    logic [15:0] bad_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic toggle_rdy = 1'b0;

    // Values captured on the accept cycle of the last beat, and status one edge later.
    logic        o_v;
    logic [15:0] o_d;
    logic [1:0]  o_k;
    logic        o_l;
    logic        s_v, s_ok, s_ce, s_le;
    logic [3:0]  s_mt;

    checksum_checker dut (
        .aclk(aclk), .arst(arst),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
        .out_tkeep(out_tkeep), .out_tlast(out_tlast),
        .status_valid(status_valid), .status_ok(status_ok), .status_cks_err(status_cks_err),
        .status_len_err(status_len_err), .status_msg_type(status_msg_type),
        .good_count(good_count), .bad_count(bad_count)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (toggle_rdy) out_tready <= ~out_tready;
    end

    task automatic beat(input logic [15:0] d, input logic l);
        int n = 0;
        @(negedge aclk);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        forever begin
            #1;
            o_v = out_tvalid; o_d = out_tdata; o_k = out_tkeep; o_l = out_tlast;
            if (in_tready) break;
            n++;
            if (n > 50) begin
                n_checks++;
                $display("FAIL beat_timeout data=%h in_tready=%b required=1", d, in_tready);
                break;
            end
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        s_v = status_valid; s_ok = status_ok; s_ce = status_cks_err;
        s_le = status_len_err; s_mt = status_msg_type;
    endtask

    task automatic test_reset();
        @(negedge aclk);
        arst = 1'b1;
        in_tvalid = 1'b1;
        in_tdata = 16'h1234;
        #1;
        n_checks++;
        if (out_tvalid !== 1'b0) $display("FAIL reset_out_tvalid got=%b exp=0", out_tvalid);
        else n_pass++;
        n_checks++;
        if ({status_valid, good_count, bad_count} !== 33'd0)
            $display("FAIL reset_status got=%b/%h/%h exp=0/0000/0000", status_valid, good_count, bad_count);
        else n_pass++;
        n_checks++;
        if (in_tready !== out_tready) $display("FAIL reset_in_tready got=%b exp=%b", in_tready, out_tready);
        else n_pass++;
        @(negedge aclk);
        arst = 1'b0;
        in_tvalid = 1'b0;
        #1;
        n_checks++;
        if (out_tvalid !== 1'b0) $display("FAIL idle_out_tvalid got=%b exp=0", out_tvalid);
        else n_pass++;
    endtask

    task automatic test_good_even(input logic [15:0] exp_good);
        beat(16'h0002, 1'b0);
        n_checks++;
        if ({o_v, o_d, o_k, o_l} !== {1'b1, 16'h0002, 2'b11, 1'b0})
            $display("FAIL even_hdr got=%b/%h/%b/%b exp=1/0002/11/0", o_v, o_d, o_k, o_l);
        else n_pass++;
        beat(16'hABCD, 1'b0);
        n_checks++;
        if ({o_v, o_d, o_k, o_l, s_v} !== {1'b1, 16'hABCD, 2'b11, 1'b1, 1'b0})
            $display("FAIL even_data got=%b/%h/%b/%b sv=%b exp=1/abcd/11/1 sv=0", o_v, o_d, o_k, o_l, s_v);
        else n_pass++;
        beat(16'h6400, 1'b1);
        n_checks++;
        if ({o_v, s_v, s_ok, s_ce, s_le, s_mt} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0})
            $display("FAIL even_status got=ov%b v%b ok%b ce%b le%b mt%h exp=ov0 v1 ok1 ce0 le0 mt0",
                     o_v, s_v, s_ok, s_ce, s_le, s_mt);
        else n_pass++;
        n_checks++;
        if (good_count !== exp_good) $display("FAIL even_good_count got=%0d exp=%0d", good_count, exp_good);
        else n_pass++;
    endtask

    task automatic test_good_odd();
        beat(16'h3001, 1'b0);
        n_checks++;
        if ({o_v, o_d, o_k, o_l} !== {1'b1, 16'h3001, 2'b11, 1'b0})
            $display("FAIL odd_hdr got=%b/%h/%b/%b exp=1/3001/11/0", o_v, o_d, o_k, o_l);
        else n_pass++;
        beat(16'h5A6B, 1'b1);
        n_checks++;
        if ({o_v, o_d, o_k, o_l} !== {1'b1, 16'h5A00, 2'b10, 1'b1})
            $display("FAIL odd_final got=%b/%h/%b/%b exp=1/5a00/10/1", o_v, o_d, o_k, o_l);
        else n_pass++;
        n_checks++;
        if ({s_v, s_ok, s_ce, s_le, s_mt, good_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 16'd2})
            $display("FAIL odd_status got=v%b ok%b ce%b le%b mt%h good%0d exp=v1 ok1 ce0 le0 mt3 good2",
                     s_v, s_ok, s_ce, s_le, s_mt, good_count);
        else n_pass++;
    endtask

    task automatic test_cks_err();
        beat(16'h0002, 1'b0);
        beat(16'hABCD, 1'b0);
        n_checks++;
        if ({o_v, o_d, o_l} !== {1'b1, 16'hABCD, 1'b1})
            $display("FAIL ckserr_data got=%b/%h/%b exp=1/abcd/1", o_v, o_d, o_l);
        else n_pass++;
        beat(16'h6500, 1'b1);
        n_checks++;
        if ({s_v, s_ok, s_ce, s_le, bad_count, good_count} !== {4'b1010, 16'd1, 16'd2})
            $display("FAIL ckserr_status got=v%b ok%b ce%b le%b bad%0d good%0d exp=v1 ok0 ce1 le0 bad1 good2",
                     s_v, s_ok, s_ce, s_le, bad_count, good_count);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        beat(16'hA000, 1'b0);
        n_checks++;
        if ({o_v, o_d, o_k, o_l} !== {1'b1, 16'hA000, 2'b11, 1'b1})
            $display("FAIL zlen_hdr got=%b/%h/%b/%b exp=1/a000/11/1", o_v, o_d, o_k, o_l);
        else n_pass++;
        beat(16'hA000, 1'b1);
        n_checks++;
        if ({o_v, s_v, s_ok, s_mt, good_count} !== {1'b0, 1'b1, 1'b1, 4'hA, 16'd3})
            $display("FAIL zlen_status got=ov%b v%b ok%b mt%h good%0d exp=ov0 v1 ok1 mta good3",
                     o_v, s_v, s_ok, s_mt, good_count);
        else n_pass++;
    endtask

    task automatic test_len_err();
        beat(16'h0004, 1'b0);
        beat(16'h1111, 1'b1);
        n_checks++;
        if ({o_v, o_d, o_k, o_l} !== {1'b1, 16'h1111, 2'b11, 1'b1})
            $display("FAIL lenerr_data got=%b/%h/%b/%b exp=1/1111/11/1", o_v, o_d, o_k, o_l);
        else n_pass++;
        n_checks++;
        if ({s_v, s_ok, s_ce, s_le, bad_count} !== {4'b1001, 16'd2})
            $display("FAIL lenerr_status got=v%b ok%b ce%b le%b bad%0d exp=v1 ok0 ce0 le1 bad2",
                     s_v, s_ok, s_ce, s_le, bad_count);
        else n_pass++;
        test_good_even(16'd4);
    endtask

    task automatic test_discard();
        beat(16'hA000, 1'b0);
        beat(16'hA000, 1'b0);
        n_checks++;
        if ({s_v, s_ok, s_ce, s_le, bad_count} !== {4'b1001, 16'd3})
            $display("FAIL discard_status got=v%b ok%b ce%b le%b bad%0d exp=v1 ok0 ce0 le1 bad3",
                     s_v, s_ok, s_ce, s_le, bad_count);
        else n_pass++;
        beat(16'h1234, 1'b0);
        beat(16'h5678, 1'b1);
        n_checks++;
        if ({o_v, s_v, bad_count, good_count} !== {2'b00, 16'd3, 16'd4})
            $display("FAIL discard_drop got=ov%b sv%b bad%0d good%0d exp=ov0 sv0 bad3 good4",
                     o_v, s_v, bad_count, good_count);
        else n_pass++;
    endtask

    task automatic test_backpressure_reset();
        toggle_rdy = 1'b1;
        test_good_even(16'd5);
        beat(16'h0002, 1'b0);
        beat(16'hABCD, 1'b0);
        toggle_rdy = 1'b0;
        @(negedge aclk);
        arst = 1'b1;
        in_tvalid = 1'b1;
        #1;
        n_checks++;
        if ({out_tvalid, status_valid, good_count, bad_count} !== 34'd0)
            $display("FAIL midreset got=ov%b sv%b good%0d bad%0d exp=ov0 sv0 good0 bad0",
                     out_tvalid, status_valid, good_count, bad_count);
        else n_pass++;
        @(negedge aclk);
        arst = 1'b0;
        in_tvalid = 1'b0;
        out_tready = 1'b1;
        beat(16'hA000, 1'b0);
        n_checks++;
        if ({o_v, o_d, o_l, s_v} !== {1'b1, 16'hA000, 1'b1, 1'b0})
            $display("FAIL postreset_hdr got=%b/%h/%b sv%b exp=1/a000/1 sv0", o_v, o_d, o_l, s_v);
        else n_pass++;
        beat(16'hA000, 1'b1);
        n_checks++;
        if ({s_v, s_ok, good_count, bad_count} !== {2'b11, 16'd1, 16'd0})
            $display("FAIL postreset_status got=v%b ok%b good%0d bad%0d exp=v1 ok1 good1 bad0",
                     s_v, s_ok, good_count, bad_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_even(16'd1);
        test_good_odd();
        test_cks_err();
        test_zero_len();
        test_len_err();
        test_discard();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/checksum_checker.md
CHECKSUM_CHECKER -- requirements
Module: checksum_checker

Interface
REQ-001 aclk  in  1  sole clock; all state changes on rising edge.
REQ-002 arst  in  1  reset, asynchronous, active-high.
REQ-003 in_tvalid/in_tready/in_tdata[15:0]/in_tlast  in/out/in/in  AXI4-stream input of checksummed packets.
REQ-004 out_tvalid/out_tready/out_tdata[15:0]/out_tkeep[1:0]/out_tlast  out/in/out/out/out  AXI4-stream output of stripped packets.
REQ-005 status_valid  out  1  one-cycle pulse per completed packet.
REQ-006 status_ok, status_cks_err, status_len_err  out  1 each  packet result, valid with status_valid.
REQ-007 status_msg_type  out  4  header[15:12] of reported packet.
REQ-008 good_count, bad_count  out  16 each  saturating packet counters.

Function
REQ-009 Packet format SHALL be: header beat (msg_type[15:12], L=[11:0] payload bytes), then payload bytes big-endian per beat, then one XOR checksum byte over all header+payload bytes; T=2+L bytes before checksum.
REQ-010 Odd T: final beat SHALL be {last data byte, checksum}; even T: final beat SHALL be {checksum, 8'h00}, low byte ignored.
REQ-011 Path SHALL be combinational, zero latency: forwarded beat -> out_tvalid=in_tvalid, in_tready=out_tready, out_tdata=in_tdata unless stated.
REQ-012 States SHALL be HDR, DATA, CKS, DISCARD; reset state HDR.
REQ-013 HDR: header beat forwarded, keep=11; latch L, msg_type; running XOR = hdr[15:8]^hdr[7:0]; remaining-beat counter (12 bits) loaded.
REQ-014 HDR with L=0: header beat SHALL carry out_tlast=1; next state CKS.
REQ-015 HDR with L>0 and in_tlast=1: forward with out_tlast=1, report len_err, stay HDR.
REQ-016 DATA non-final beat: forward keep=11, XOR both bytes, decrement counter.
REQ-017 DATA final beat, odd T: output {in_tdata[15:8],8'h00}, keep=10, out_tlast=1; check XOR^data[15:8]==data[7:0]; report; next HDR.
REQ-018 DATA final data beat, even T: forward keep=11, out_tlast=1, XOR both bytes; next CKS.
REQ-019 CKS: in_tready=1, out_tvalid=0; on accept compare in_tdata[15:8] with XOR; report; next HDR.
REQ-020 in_tlast earlier than expected final beat: forward with out_tlast=1, keep=11, report len_err (cks_err=0), next HDR.
REQ-021 Expected final (odd) or CKS beat accepted without in_tlast: complete per REQ-017/019 output, report len_err (cks_err per compare), next DISCARD.
REQ-022 DISCARD: in_tready=1, out_tvalid=0, drop beats until in_tlast accepted, then HDR; no further status.
REQ-023 Report: status_valid=1 for exactly the accept cycle's following clock edge (registered, 1-cycle latency); status_ok=!cks_err&&!len_err.
REQ-024 good_count increments on status_ok, else bad_count increments; each saturates at 16'hFFFF.
REQ-025 Backpressure (out_tready=0) SHALL stall forwarded beats without changing state, XOR or counters.
REQ-026 Checksum mismatch SHALL NOT suppress already-forwarded data.

Reset
REQ-027 arst SHALL immediately force: state HDR, XOR 0, beat counter 0, status_* 0, counters 0, in_tready=out_tready-derived per HDR, out_tvalid follows in_tvalid only after release.
REQ-028 Reset mid-packet SHALL abandon it with no status; next accepted beat is a header.

Verification
REQ-029 0x0002,0xABCD,0x6400(last) -> out 0x0002,0xABCD(last,keep 11); status_ok; good_count=1.
REQ-030 0x3001,0x5A6B(last) -> out 0x3001,0x5A00(last,keep 10); status_ok, msg_type=3.
REQ-031 0x0002,0xABCD,0x6500(last) -> same output as REQ-029; cks_err=1; bad_count=1.
REQ-032 0xA000,0xA000(last) -> out 0xA000(last,keep 11); status_ok.
REQ-033 0x0004,0x1111(last) -> out 0x0004,0x1111(last); len_err=1; next packet decoded normally.
REQ-034 REQ-029 stimulus with out_tready toggling every cycle, then arst mid-second packet -> identical output, no status for aborted packet, good_count=0 after reset.
